// File: rtl/btb_pkg.sv
// Shared geometry, entry layout and index/tag/counter helpers for the branch target buffer.
// Table geometry is fixed here so the entry struct and the RTL that uses it agree.
package btb_pkg;

    localparam int unsigned PC_W    = 32;
    localparam int unsigned IDX_W   = 4;
    localparam int unsigned TAG_W   = 8;
    localparam int unsigned CTR_W   = 2;
    localparam int unsigned ENTRIES = 2 ** IDX_W;

    // Allocation value: weakly taken (MSB set, rest clear)
    localparam logic [CTR_W-1:0] CTR_WEAK = CTR_W'(1) << (CTR_W - 1);

    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] tag;
        logic [PC_W-1:0]  target;
        logic [CTR_W-1:0] ctr;
    } btb_entry_t;

    function automatic logic [IDX_W-1:0] idx_of(input logic [PC_W-1:0] pc);
        return IDX_W'(pc >> 2);
    endfunction

    function automatic logic [TAG_W-1:0] tag_of(input logic [PC_W-1:0] pc);
        return TAG_W'(pc >> (IDX_W + 2));
    endfunction

    function automatic logic [CTR_W-1:0] sat_inc(input logic [CTR_W-1:0] ctr);
        return (ctr == '1) ? ctr : ctr + CTR_W'(1);
    endfunction

    function automatic logic [CTR_W-1:0] sat_dec(input logic [CTR_W-1:0] ctr);
        return (ctr == '0) ? ctr : ctr - CTR_W'(1);
    endfunction

endpackage

// File: rtl/btb_sat_counter.sv
// Next-value logic for one saturating direction counter; load wins over inc/dec.
module btb_sat_counter #(
    parameter int unsigned CTR_W = 2
) (
    input  logic [CTR_W-1:0] ctr,
    input  logic             inc,
    input  logic             dec,
    input  logic             load,
    input  logic [CTR_W-1:0] load_val,
    output logic [CTR_W-1:0] ctr_next_c
);

    always_comb begin
        ctr_next_c = ctr;
        if (load) begin
            ctr_next_c = load_val;
        end else if (inc && (ctr != '1)) begin
            ctr_next_c = ctr + CTR_W'(1);
        end else if (dec && (ctr != '0)) begin
            ctr_next_c = ctr - CTR_W'(1);
        end
    end

endmodule

// File: rtl/btb_predictor.sv
// Tagged branch target buffer: zero-latency lookup on the fetch PC, EX-stage training,
// misprediction flush/redirect and branch/mispredict statistics.
module btb_predictor
    import btb_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             memory_stall,
    input  logic [PC_W-1:0]  lookup_pc,
    output logic             pred_hit,
    output logic             pred_taken,
    output logic [PC_W-1:0]  pred_target,
    input  logic             upd_valid,
    input  logic [PC_W-1:0]  upd_pc,
    input  logic             upd_taken,
    input  logic [PC_W-1:0]  upd_target,
    input  logic             upd_pred_taken,
    input  logic [PC_W-1:0]  upd_pred_target,
    output logic             flush,
    output logic [PC_W-1:0]  redirect_pc,
    input  logic             stats_clr,
    output logic [CNT_W-1:0] branch_cnt,
    output logic [CNT_W-1:0] mispredict_cnt
);

    btb_entry_t table_q [ENTRIES];

    btb_entry_t       lk_entry;
    btb_entry_t       up_entry;
    btb_entry_t       new_entry;
    logic [IDX_W-1:0] up_idx;
    logic             up_hit;
    logic [PC_W-1:0]  correct_pc;
    logic             mis;
    logic             do_upd;
    logic             do_write;
    logic [CTR_W-1:0] ctr_next;

    // Fetch-side lookup reads the registered table, so a same-cycle write is not yet visible
    always_comb begin
        lk_entry    = table_q[idx_of(lookup_pc)];
        pred_hit    = lk_entry.valid && (lk_entry.tag == tag_of(lookup_pc));
        pred_taken  = pred_hit && lk_entry.ctr[CTR_W-1];
        pred_target = pred_taken ? lk_entry.target : lookup_pc + PC_W'(4);
    end

    // Resolution: compare the real next PC with the one fetch actually followed
    always_comb begin
        correct_pc  = upd_taken ? upd_target : upd_pc + PC_W'(4);
        mis         = upd_valid && (correct_pc != upd_pred_target);
        flush       = mis;
        redirect_pc = correct_pc;
        do_upd      = upd_valid && !memory_stall;
    end

    always_comb begin
        up_idx    = idx_of(upd_pc);
        up_entry  = table_q[up_idx];
        up_hit    = up_entry.valid && (up_entry.tag == tag_of(upd_pc));
        // Not-taken misses never allocate
        do_write  = do_upd && (up_hit || upd_taken);
        new_entry = '{valid:  1'b1,
                      tag:    tag_of(upd_pc),
                      target: upd_taken ? upd_target : up_entry.target,
                      ctr:    ctr_next};
    end

    btb_sat_counter #(
        .CTR_W (CTR_W)
    ) u_sat_counter (
        .ctr        (up_entry.ctr),
        .inc        (upd_taken),
        .dec        (!upd_taken),
        .load       (!up_hit),
        .load_val   (CTR_WEAK),
        .ctr_next_c (ctr_next)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                table_q[i] <= '0;
            end
        end else if (do_write) begin
            table_q[up_idx] <= new_entry;
        end
    end

    // Clear takes priority and ignores the stall
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            branch_cnt     <= '0;
            mispredict_cnt <= '0;
        end else if (stats_clr) begin
            branch_cnt     <= '0;
            mispredict_cnt <= '0;
        end else if (do_upd) begin
            branch_cnt <= branch_cnt + CNT_W'(1);
            if (mis) begin
                mispredict_cnt <= mispredict_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_btb_predictor.sv
// Directed self-checking bench for btb_predictor (statistics counters narrowed to 4 bits).
module tb_btb_predictor;

    localparam int unsigned TB_PC_W  = 32;
    localparam int unsigned TB_CNT_W = 4;

    logic                  clk;
    logic                  rst_n;
    logic                  memory_stall;
    logic [TB_PC_W-1:0]    lookup_pc;
    logic                  pred_hit;
    logic                  pred_taken;
    logic [TB_PC_W-1:0]    pred_target;
    logic                  upd_valid;
    logic [TB_PC_W-1:0]    upd_pc;
    logic                  upd_taken;
    logic [TB_PC_W-1:0]    upd_target;
    logic                  upd_pred_taken;
    logic [TB_PC_W-1:0]    upd_pred_target;
    logic                  flush;
    logic [TB_PC_W-1:0]    redirect_pc;
    logic                  stats_clr;
    logic [TB_CNT_W-1:0]   branch_cnt;
    logic [TB_CNT_W-1:0]   mispredict_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    btb_predictor #(
        .CNT_W (TB_CNT_W)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .memory_stall    (memory_stall),
        .lookup_pc       (lookup_pc),
        .pred_hit        (pred_hit),
        .pred_taken      (pred_taken),
        .pred_target     (pred_target),
        .upd_valid       (upd_valid),
        .upd_pc          (upd_pc),
        .upd_taken       (upd_taken),
        .upd_target      (upd_target),
        .upd_pred_taken  (upd_pred_taken),
        .upd_pred_target (upd_pred_target),
        .flush           (flush),
        .redirect_pc     (redirect_pc),
        .stats_clr       (stats_clr),
        .branch_cnt      (branch_cnt),
        .mispredict_cnt  (mispredict_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_upd(input logic v, input logic [31:0] pc, input logic tk,
                             input logic [31:0] tgt, input logic ptk, input logic [31:0] ptgt);
        upd_valid       = v;
        upd_pc          = pc;
        upd_taken       = tk;
        upd_target      = tgt;
        upd_pred_taken  = ptk;
        upd_pred_target = ptgt;
    endtask

    task automatic expect_lookup(input string tag, input logic [31:0] pc, input logic hit,
                                 input logic tk, input logic [31:0] tgt);
        lookup_pc = pc;
        #1;
        check({tag, "_hit"}, 32'(pred_hit), 32'(hit));
        check({tag, "_taken"}, 32'(pred_taken), 32'(tk));
        check({tag, "_target"}, pred_target, tgt);
    endtask

    task automatic expect_cnts(input string tag, input logic [31:0] br, input logic [31:0] mp);
        check({tag, "_branch_cnt"}, 32'(branch_cnt), br);
        check({tag, "_mispredict_cnt"}, 32'(mispredict_cnt), mp);
    endtask

    initial begin
        rst_n        = 1'b0;
        memory_stall = 1'b0;
        stats_clr    = 1'b0;
        lookup_pc    = 32'h40;
        drive_upd(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        #12;
        rst_n = 1'b1;
        step();

        // Reset state
        expect_lookup("rst", 32'h40, 1'b0, 1'b0, 32'h44);
        check("rst_flush", 32'(flush), 32'd0);
        expect_cnts("rst", 32'd0, 32'd0);

        // Allocate on taken miss; same-cycle lookup still sees the old entry
        drive_upd(1'b1, 32'h40, 1'b1, 32'h100, 1'b0, 32'h44);
        #1;
        check("alloc_flush", 32'(flush), 32'd1);
        check("alloc_redirect", redirect_pc, 32'h100);
        check("alloc_same_cycle_hit", 32'(pred_hit), 32'd0);
        step();
        drive_upd(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        expect_lookup("alloc_next", 32'h40, 1'b1, 1'b1, 32'h100);
        expect_cnts("alloc", 32'd1, 32'd1);

        // Three correctly predicted taken updates saturate the counter at 3
        drive_upd(1'b1, 32'h40, 1'b1, 32'h100, 1'b1, 32'h100);
        #1;
        check("correct_flush", 32'(flush), 32'd0);
        repeat (3) step();
        // First not-taken: 3 -> 2, still predicts taken
        drive_upd(1'b1, 32'h40, 1'b0, 32'h0, 1'b1, 32'h100);
        #1;
        check("nt_flush", 32'(flush), 32'd1);
        check("nt_redirect", redirect_pc, 32'h44);
        step();
        expect_lookup("nt1", 32'h40, 1'b1, 1'b1, 32'h100);
        step();
        drive_upd(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        // Second not-taken: 2 -> 1, falls through
        expect_lookup("nt2", 32'h40, 1'b1, 1'b0, 32'h44);
        expect_cnts("sat", 32'd6, 32'd3);

        // 0x80 aliases index 0 with a different tag
        expect_lookup("alias_pre", 32'h80, 1'b0, 1'b0, 32'h84);
        drive_upd(1'b1, 32'h80, 1'b1, 32'h200, 1'b0, 32'h84);
        step();
        drive_upd(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        expect_lookup("alias_new", 32'h80, 1'b1, 1'b1, 32'h200);
        expect_lookup("alias_old", 32'h40, 1'b0, 1'b0, 32'h44);
        expect_cnts("alias", 32'd7, 32'd4);

        // Stalled mispredict: flush held, nothing written
        memory_stall = 1'b1;
        drive_upd(1'b1, 32'h40, 1'b1, 32'h300, 1'b0, 32'h44);
        for (int i = 0; i < 3; i++) begin
            #1;
            check("stall_flush", 32'(flush), 32'd1);
            step();
        end
        expect_lookup("stall_tbl", 32'h80, 1'b1, 1'b1, 32'h200);
        check("stall_tbl_40", 32'(pred_hit), 32'd1);
        expect_cnts("stall", 32'd7, 32'd4);
        memory_stall = 1'b0;
        step();
        drive_upd(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        expect_cnts("unstall", 32'd8, 32'd5);
        expect_lookup("unstall_40", 32'h40, 1'b1, 1'b1, 32'h300);

        // Clear, then wrap branch_cnt with 16 correctly predicted not-taken misses
        stats_clr = 1'b1;
        step();
        stats_clr = 1'b0;
        expect_cnts("clr", 32'd0, 32'd0);
        drive_upd(1'b1, 32'h1000, 1'b0, 32'h0, 1'b0, 32'h1004);
        repeat (15) step();
        expect_cnts("wrap15", 32'd15, 32'd0);
        step();
        drive_upd(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        expect_cnts("wrap16", 32'd0, 32'd0);
        expect_lookup("noalloc_nt", 32'h1000, 1'b0, 1'b0, 32'h1004);

        // stats_clr beats a same-cycle mispredicting update
        drive_upd(1'b1, 32'h2004, 1'b1, 32'h400, 1'b0, 32'h2008);
        step();
        expect_cnts("pre_clr", 32'd1, 32'd1);
        stats_clr = 1'b1;
        step();
        stats_clr = 1'b0;
        drive_upd(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        expect_cnts("clr_upd", 32'd0, 32'd0);
        expect_lookup("pre_rst", 32'h2004, 1'b1, 1'b1, 32'h400);

        // Asynchronous reset mid-stream wipes the table immediately
        rst_n = 1'b0;
        expect_lookup("midrst_2004", 32'h2004, 1'b0, 1'b0, 32'h2008);
        expect_lookup("midrst_40", 32'h40, 1'b0, 1'b0, 32'h44);
        #3;
        rst_n = 1'b1;
        step();
        expect_lookup("postrst_80", 32'h80, 1'b0, 1'b0, 32'h84);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
